// File: rtl/vna_packet_scheduler.sv
// Packet scheduler: snapshots per-channel accumulator results on a trigger and
// streams them as one AXI4-Stream packet (header, then value/count beat pairs).
// Triggers that arrive while a packet is draining are counted as drops and
// flagged in the next packet header.
module vna_packet_scheduler #(
  parameter int          NUM_CH   = 4,
  parameter logic [15:0] MAGIC    = 16'hA55A,
  parameter logic [31:0] SEQ_INIT = 32'h0    // sequence number loaded at reset
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        en,
  input  logic        trigger,
  input  logic [63:0] val_1,
  input  logic [63:0] val_2,
  input  logic [63:0] val_3,
  input  logic [63:0] val_4,
  input  logic [31:0] cnt_1,
  input  logic [31:0] cnt_2,
  input  logic [31:0] cnt_3,
  input  logic [31:0] cnt_4,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [31:0] seq_num,
  output logic [15:0] drop_cnt
);
  localparam int LAST = 2 * NUM_CH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  b_q, b_d;
  logic [63:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        busy_q, busy_d;
  logic [31:0] seq_q, seq_d;
  logic [15:0] drop_q, drop_d;
  logic        ovr_q, ovr_d;

  logic [63:0] vin [4];
  logic [31:0] cin [4];
  logic [63:0] val_s_q [4];
  logic [31:0] cnt_s_q [4];

  logic        hs, last_hs, accept;
  logic [3:0]  nb;
  logic [1:0]  k_val, k_cnt;
  logic [63:0] nxt_beat, hdr;

  assign vin[0] = val_1;  assign vin[1] = val_2;
  assign vin[2] = val_3;  assign vin[3] = val_4;
  assign cin[0] = cnt_1;  assign cin[1] = cnt_2;
  assign cin[2] = cnt_3;  assign cin[3] = cnt_4;

  // A trigger is taken when idle, or on the closing handshake of the current
  // packet so consecutive packets stream without a bubble.
  assign hs      = tvalid_q & m_axis_tready;
  assign last_hs = hs & tlast_q;
  assign accept  = trigger & en & ((state_q == IDLE) | last_hs);

  // Select the beat following b_q from the snapshot: odd beats carry values,
  // even beats carry the channel index plus sample count.
  always_comb begin
    nb       = b_q + 4'd1;
    k_val    = 2'((nb - 4'd1) >> 1);
    k_cnt    = 2'((nb - 4'd2) >> 1);
    nxt_beat = nb[0] ? val_s_q[k_val] : {6'd0, k_cnt, 24'd0, cnt_s_q[k_cnt]};
    hdr      = {MAGIC, 8'(NUM_CH), 7'd0, ovr_q, seq_q};
  end

  // Next-state logic for the packet FSM, stream registers and drop accounting.
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    ovr_d    = ovr_q;
    if (accept) begin
      state_d  = SEND;
      b_d      = 4'd0;
      tdata_d  = hdr;
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
      busy_d   = 1'b1;
      seq_d    = seq_q + 32'd1;
      ovr_d    = 1'b0;
    end else begin
      if (hs) begin
        if (tlast_q) begin
          state_d  = IDLE;
          b_d      = 4'd0;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
        end else begin
          b_d     = nb;
          tdata_d = nxt_beat;
          tlast_d = (nb == 4'(LAST));
        end
      end
      // Not accepted while enabled can only mean a packet is still in flight.
      if (trigger & en) begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        ovr_d = 1'b1;
      end
    end
  end

  // Control and stream registers, synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!rst) begin
      state_q  <= IDLE;
      b_q      <= 4'd0;
      tdata_q  <= 64'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      seq_q    <= SEQ_INIT;
      drop_q   <= 16'd0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovr_q    <= ovr_d;
    end
  end

  // Channel snapshot; payload never depends on live inputs after the trigger.
  always_ff @(posedge aclk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        val_s_q[i] <= vin[i];
        cnt_s_q[i] <= cin[i];
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign seq_num       = seq_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_vna_packet_scheduler.sv
// Bench for vna_packet_scheduler: a 4-channel instance and a 1-channel instance
// with a near-wrap sequence reset value. Expected beats are queued at trigger
// time and compared as the stream hands them off.
module tb_vna_packet_scheduler;
  logic        aclk, rst, en, trigger, tready;
  logic        en1, trig1, rdy1;
  logic [63:0] vals [4];
  logic [31:0] cnts [4];
  logic [63:0] tdata, tdata1;
  logic        tvalid, tlast, busy, tvalid1, tlast1, busy1;
  logic [31:0] seq, seq1;
  logic [15:0] drop, drop1;

  logic [64:0] q4 [$];
  logic [64:0] q1 [$];
  logic [31:0] e_seq, e_seq1;
  logic        e_ovr, e_ovr1;
  logic [15:0] e_drop;
  int          passed = 0, total = 0;

  vna_packet_scheduler #(.NUM_CH(4)) u4 (
    .aclk(aclk), .rst(rst), .en(en), .trigger(trigger),
    .val_1(vals[0]), .val_2(vals[1]), .val_3(vals[2]), .val_4(vals[3]),
    .cnt_1(cnts[0]), .cnt_2(cnts[1]), .cnt_3(cnts[2]), .cnt_4(cnts[3]),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .busy(busy), .seq_num(seq), .drop_cnt(drop));

  vna_packet_scheduler #(.NUM_CH(1), .SEQ_INIT(32'hFFFF_FFFE)) u1 (
    .aclk(aclk), .rst(rst), .en(en1), .trigger(trig1),
    .val_1(vals[0]), .val_2(vals[1]), .val_3(vals[2]), .val_4(vals[3]),
    .cnt_1(cnts[0]), .cnt_2(cnts[1]), .cnt_3(cnts[2]), .cnt_4(cnts[3]),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(rdy1),
    .m_axis_tlast(tlast1), .busy(busy1), .seq_num(seq1), .drop_cnt(drop1));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected packet: header, then value and tagged count per channel.
  task automatic push_pkt(input int u, input int n, input logic ovr, input logic [31:0] s);
    logic [64:0] b;
    b = {1'b0, 16'hA55A, 8'(n), 7'd0, ovr, s};
    if (u == 0) q4.push_back(b); else q1.push_back(b);
    for (int k = 0; k < n; k++) begin
      b = {1'b0, vals[k]};
      if (u == 0) q4.push_back(b); else q1.push_back(b);
      b = {(k == n - 1), 8'(k), 24'd0, cnts[k]};
      if (u == 0) q4.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic fire4();
    trigger = 1'b1;
    push_pkt(0, 4, e_ovr, e_seq);
    e_seq = e_seq + 32'd1; e_ovr = 1'b0;
    @(posedge aclk); #1 trigger = 1'b0;
  endtask

  task automatic drop4();
    trigger = 1'b1;
    if (e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
    e_ovr = 1'b1;
    @(posedge aclk); #1 trigger = 1'b0;
  endtask

  task automatic fire1();
    trig1 = 1'b1;
    push_pkt(1, 1, e_ovr1, e_seq1);
    e_seq1 = e_seq1 + 32'd1; e_ovr1 = 1'b0;
    @(posedge aclk); #1 trig1 = 1'b0;
  endtask

  task automatic drain(input int u, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(posedge aclk); #1;
      if (u == 0 && q4.size() == 0 && !tvalid) break;
      if (u == 1 && q1.size() == 0 && !tvalid1) break;
    end
    chk("drain_done", 65'(i < maxc), 65'd1);
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 4; k++) begin
      vals[k] = {$urandom, $urandom};
      cnts[k] = $urandom;
    end
  endtask

  // Scoreboard and stall-stability monitor, 4-channel stream.
  logic        pv4, pr4;
  logic [64:0] pb4;
  always @(negedge aclk) begin
    if (rst) begin
      if (pv4 && !pr4) begin
        chk("stall_tvalid", 65'(tvalid), 65'd1);
        chk("stall_data", {tlast, tdata}, pb4);
      end
      if (tvalid && tready) begin
        if (q4.size() == 0) chk("extra_beat", 65'(tvalid), 65'd0);
        else chk("beat4", {tlast, tdata}, q4.pop_front());
      end
      pv4 <= tvalid; pr4 <= tready; pb4 <= {tlast, tdata};
    end else begin
      pv4 <= 1'b0; pr4 <= 1'b0; pb4 <= '0;
    end
  end

  // Same for the 1-channel stream.
  logic        pv1, pr1;
  logic [64:0] pb1;
  always @(negedge aclk) begin
    if (rst) begin
      if (pv1 && !pr1) chk("stall1_data", {tlast1, tdata1}, pb1);
      if (tvalid1 && rdy1) begin
        if (q1.size() == 0) chk("extra_beat1", 65'(tvalid1), 65'd0);
        else chk("beat1", {tlast1, tdata1}, q1.pop_front());
      end
      pv1 <= tvalid1; pr1 <= rdy1; pb1 <= {tlast1, tdata1};
    end else begin
      pv1 <= 1'b0; pr1 <= 1'b0; pb1 <= '0;
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; trigger = 1'b0; tready = 1'b1;
    en1 = 1'b1; trig1 = 1'b0; rdy1 = 1'b1;
    e_seq = 0; e_ovr = 0; e_drop = 0; e_seq1 = 32'hFFFF_FFFE; e_ovr1 = 0;
    for (int k = 0; k < 4; k++) begin vals[k] = '0; cnts[k] = '0; end
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", 65'(tvalid), 65'd0);
    chk("rst_tlast", 65'(tlast), 65'd0);
    chk("rst_tdata", 65'(tdata), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_seq", 65'(seq), 65'd0);
    chk("rst_drop", 65'(drop), 65'd0);
    rst = 1'b1;
    @(posedge aclk); #1;

    // 1: single packet, always ready
    vals[0] = 64'h1234_5678_ABCD_EF01; cnts[0] = 32'd1;
    vals[1] = 64'h2; cnts[1] = 32'd20; vals[2] = 64'h3; cnts[2] = 32'd30;
    vals[3] = 64'h4; cnts[3] = 32'd40;
    fire4();
    chk("latency_tvalid", 65'(tvalid), 65'd1);
    chk("first_header", 65'(tdata), 65'hA55A_0400_0000_0000);
    chk("busy_send", 65'(busy), 65'd1);
    drain(0, 20);
    chk("seq_after1", 65'(seq), 65'(e_seq));
    chk("busy_idle", 65'(busy), 65'd0);

    // 2: backpressure toggling with live inputs changing every cycle
    randomize_inputs();
    tready = 1'b0;
    fire4();
    for (int i = 0; i < 40; i++) begin
      tready = ~tready;
      randomize_inputs();
      @(posedge aclk); #1;
    end
    tready = 1'b1;
    drain(0, 20);

    // 3: overrun while stalled; ovr flag appears once then clears
    tready = 1'b0;
    fire4();
    repeat (3) drop4();
    chk("drop_cnt3", 65'(drop), 65'(e_drop));
    chk("busy_stalled", 65'(busy), 65'd1);
    tready = 1'b1;
    drain(0, 20);
    randomize_inputs();
    fire4();
    drain(0, 20);
    fire4();
    drain(0, 20);

    // 4: trigger on the closing handshake streams the next packet seamlessly
    randomize_inputs();
    fire4();
    begin
      int i;
      for (i = 0; i < 20; i++) begin
        if (tlast) break;
        @(posedge aclk); #1;
      end
      chk("found_tlast", 65'(i < 20), 65'd1);
    end
    randomize_inputs();
    fire4();
    chk("b2b_tvalid", 65'(tvalid), 65'd1);
    chk("b2b_tlast", 65'(tlast), 65'd0);
    drain(0, 20);
    chk("seq_b2b", 65'(seq), 65'(e_seq));

    // 5: disabled triggers are ignored; reset aborts a packet
    en = 1'b0; trigger = 1'b1;
    repeat (3) @(posedge aclk);
    #1 trigger = 1'b0;
    chk("en0_tvalid", 65'(tvalid), 65'd0);
    chk("en0_drop", 65'(drop), 65'(e_drop));
    chk("en0_seq", 65'(seq), 65'(e_seq));
    en = 1'b1;
    fire4();
    repeat (3) @(posedge aclk);
    #1 rst = 1'b0;
    @(posedge aclk); #1;
    chk("abort_tvalid", 65'(tvalid), 65'd0);
    chk("abort_seq", 65'(seq), 65'd0);
    chk("abort_drop", 65'(drop), 65'd0);
    q4.delete(); q1.delete();
    e_seq = 0; e_ovr = 0; e_drop = 0; e_seq1 = 32'hFFFF_FFFE; e_ovr1 = 0;
    rst = 1'b1;
    @(posedge aclk); #1;
    fire4();
    chk("post_rst_hdr", 65'(tdata), 65'hA55A_0400_0000_0000);
    drain(0, 20);

    // 6: single-channel packets, sequence wrap, drop saturation
    chk("seq1_init", 65'(seq1), 65'h0_FFFF_FFFE);
    randomize_inputs();
    fire1();
    drain(1, 10);
    chk("seq1_ff", 65'(seq1), 65'h0_FFFF_FFFF);
    randomize_inputs();
    fire1();
    drain(1, 10);
    chk("seq1_wrap", 65'(seq1), 65'd0);
    rdy1 = 1'b0;
    randomize_inputs();
    trig1 = 1'b1;
    push_pkt(1, 1, e_ovr1, e_seq1);
    e_seq1 = e_seq1 + 32'd1;
    repeat (65540) @(posedge aclk);
    #1 trig1 = 1'b0;
    e_ovr1 = 1'b1;
    chk("drop1_sat", 65'(drop1), 65'h0FFFF);
    rdy1 = 1'b1;
    drain(1, 10);
    chk("drop1_hold", 65'(drop1), 65'h0FFFF);
    fire1();
    drain(1, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
